// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster engine: colour-source modes,
// 640x480@60 default timing and the per-axis region encoding.
package vga_pkg;

  localparam logic MODE_EXT   = 1'b0;
  localparam logic MODE_CYCLE = 1'b1;

  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic [1:0] RGN_ACTIVE = 2'd0;
  localparam logic [1:0] RGN_FRONT  = 2'd1;
  localparam logic [1:0] RGN_SYNC   = 2'd2;
  localparam logic [1:0] RGN_BACK   = 2'd3;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus region decode.
// The same block serves horizontal and vertical timing.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W      = 11,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int TOTAL  = 800
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap,
  output logic [1:0]   o_region
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(TOTAL - 1));
  assign o_wrap = i_en & w_last;
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_en)  r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  always_comb begin
    o_region = RGN_BACK;
    if (r_cnt < W'(ACTIVE))                  o_region = RGN_ACTIVE;
    else if (r_cnt < W'(ACTIVE + FP))        o_region = RGN_FRONT;
    else if (r_cnt < W'(ACTIVE + FP + SYNC)) o_region = RGN_SYNC;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel enable, H/V timing, sync, blanking
// and colour muxing. Define VGA_TIMING_BORDER_EN for a white alignment border.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = VGA_CLK_DIV,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_POL   = 0,
  parameter int COLOR_W    = 4,
  parameter int FRAME_HOLD = 60
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               mode,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [10:0]        pixel_x,
  output logic [9:0]         pixel_y,
  output logic               pix_ce,
  output logic               frame_start,
  output logic               de,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B
);

  localparam int   H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   FC_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic                w_ce, w_h_wrap, w_v_en, w_fs, w_act;
  logic [1:0]          w_h_rgn, w_v_rgn;
  logic [COLOR_W-1:0]  w_r, w_g, w_b;
  logic                r_mode, r_de, r_hs, r_vs;
  logic [FC_W-1:0]     r_fcnt;
  logic [2:0]          r_cidx;
  logic [COLOR_W-1:0]  r_r, r_g, r_b;

  // With no division, the strobe still stays low until the first clock after reset.
  if (CLK_DIV > 1) begin : g_div
    logic [DIV_W-1:0] r_div;
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N)                          r_div <= '0;
      else if (r_div == DIV_W'(CLK_DIV - 1)) r_div <= '0;
      else                                   r_div <= r_div + 1'b1;
    end
    assign w_ce = (r_div == DIV_W'(CLK_DIV - 1));
  end else begin : g_nodiv
    logic r_run;
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) r_run <= 1'b0;
      else          r_run <= 1'b1;
    end
    assign w_ce = r_run;
  end

  vga_axis_counter #(
    .W(11), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .TOTAL(H_TOT)
  ) u_h (
    .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_en(w_ce),
    .o_cnt(pixel_x), .o_wrap(w_h_wrap), .o_region(w_h_rgn)
  );

  assign w_v_en = w_h_wrap & w_ce;

  vga_axis_counter #(
    .W(10), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .TOTAL(V_TOT)
  ) u_v (
    .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_en(w_v_en),
    .o_cnt(pixel_y), .o_wrap(), .o_region(w_v_rgn)
  );

  assign w_fs  = w_ce & (pixel_x == '0) & (pixel_y == '0);
  assign w_act = (w_h_rgn == RGN_ACTIVE) & (w_v_rgn == RGN_ACTIVE);

  always_comb begin
    w_r = pix_r;
    w_g = pix_g;
    w_b = pix_b;
    if (r_mode == MODE_CYCLE) begin
      w_r = {COLOR_W{r_cidx[2]}};
      w_g = {COLOR_W{r_cidx[1]}};
      w_b = {COLOR_W{r_cidx[0]}};
    end
`ifdef VGA_TIMING_BORDER_EN
    if (pixel_x == 11'd0 || pixel_x == 11'(H_ACTIVE - 1) ||
        pixel_y == 10'd0 || pixel_y == 10'(V_ACTIVE - 1)) begin
      w_r = '1;
      w_g = '1;
      w_b = '1;
    end
`endif
  end

  // Mode and colour index only move at frame boundaries so a frame is never mixed.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mode <= MODE_EXT;
      r_fcnt <= '0;
      r_cidx <= '0;
    end else if (w_fs) begin
      r_mode <= mode;
      if (r_fcnt == FC_W'(FRAME_HOLD - 1)) begin
        r_fcnt <= '0;
        r_cidx <= r_cidx + 1'b1;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_de <= 1'b0;
      r_hs <= ~SYNC_ACT;
      r_vs <= ~SYNC_ACT;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else if (w_ce) begin
      r_de <= w_act;
      r_hs <= (w_h_rgn == RGN_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      r_vs <= (w_v_rgn == RGN_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      r_r  <= w_act ? w_r : '0;
      r_g  <= w_act ? w_g : '0;
      r_b  <= w_act ? w_b : '0;
    end
  end

  assign pix_ce      = w_ce;
  assign frame_start = w_fs;
  assign de          = r_de;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster engine: pixel-clock enable, horizontal/vertical timing counters, sync generation, blanking and colour output muxing.
- Successor to the fixed 640x480 chain of divider, 800/525 counters and per-axis state FSMs.
- Timing, colour depth and sync polarity are generics. Adds pixel coordinates, data-enable, frame strobe and a selectable colour source (external or built-in frame-cycling colour).
- Sits between the pixel source (frame buffer / sprite logic) and the DE0-CV VGA pins.

Parameters:
- CLK_DIV, 2, CLOCK_50 cycles per pixel (>=1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, sync active level (0 = active low).
- COLOR_W, 4, bits per colour channel.
- FRAME_HOLD, 60, frames per step of the internal colour cycle (>=1).

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- mode  in  1  0 = external colour, 1 = internal frame-cycling colour.
- pix_r, pix_g, pix_b  in  COLOR_W each  external pixel colour for the current coordinate.
- pixel_x  out  11  horizontal counter value.
- pixel_y  out  10  vertical counter value.
- pix_ce  out  1  one-cycle pixel strobe.
- frame_start  out  1  one-cycle pulse at the pixel strobe where x=0, y=0.
- de  out  1  registered active-video flag, aligned with the RGB outputs.
- VGA_HS, VGA_VS  out  1  sync outputs.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  colour outputs, forced to 0 when blanking.

Behaviour:
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
- Pixel divider counts 0..CLK_DIV-1. pix_ce is high in the cycle the divider reaches CLK_DIV-1. When CLK_DIV=1, pix_ce is constantly 1.
- Horizontal counter advances on pix_ce and wraps H_TOT-1 -> 0.
- Vertical counter advances on pix_ce only when the horizontal counter wraps; it wraps V_TOT-1 -> 0.
- pixel_x and pixel_y are the counter values directly (combinational from registers).
- Per-axis regions in order: ACTIVE [0, ACTIVE), FRONT [ACTIVE, ACTIVE+FP), SYNC [ACTIVE+FP, ACTIVE+FP+SYNC), BACK (remainder).
- Sync and active flags are decoded from the counters and registered on pix_ce, giving one pixel of latency.
- Colour pipeline:
  - pix_r/g/b are sampled on the pix_ce that follows the presentation of (x,y).
  - The upstream source therefore has one full pixel period of latency budget.
  - VGA_* outputs are registered and update on pix_ce only.
- Sync levels: VGA_HS = SYNC_POL while the horizontal region is SYNC, otherwise ~SYNC_POL. VGA_VS follows the same rule with the vertical counter.
- de = horizontal ACTIVE AND vertical ACTIVE. RGB outputs are 0 whenever de=0.
- Internal colour source:
  - 3-bit colour index; each bit drives one full channel (all-ones or 0).
  - A frame counter increments at each frame_start. On reaching FRAME_HOLD-1 it clears and the colour index increments, wrapping 7 -> 0.
- mode is latched only at frame_start; changes mid-frame take effect on the next frame.
- Reset (asynchronous, any time, including mid-line):
  - divider, counters, frame counter and colour index go to 0; latched mode goes to 0;
  - de=0, RGB=0, HS and VS = ~SYNC_POL, frame_start=0, pix_ce=0.
  - On release, the first pix_ce occurs CLK_DIV cycles later, at x=0, y=0, with frame_start asserted.

Optional Feature:
- Macro VGA_TIMING_BORDER_EN.
- Defined: pixels on the active-area perimeter (x=0, x=H_ACTIVE-1, y=0, y=V_ACTIVE-1) output full white regardless of mode. Used for monitor alignment.
- Undefined: no override; the logic is absent.

Decomposition:
- Package vga_pkg holds:
  - the mode encoding constants (MODE_EXT, MODE_CYCLE);
  - 640x480@60 default timing constants;
  - the 2-bit region encoding (ACTIVE/FRONT/SYNC/BACK).
- Sub-module vga_axis_counter is parametrised by ACTIVE/FP/SYNC and TOTAL. Inputs: clock, reset, advance enable. Outputs: count, wrap pulse, region. It is instantiated once per axis, the vertical instance enabled by the horizontal wrap AND pix_ce.

Test Plan:
- Defaults, run after reset -> pix_ce every 2 clocks; line = 1600 clocks; frame_start period = 840000 clocks.
- HS measurement -> VGA_HS low for exactly 96 pixel strobes, starting one pixel after x=656. VGA_VS low for 2 lines starting one pixel after y=490.
- mode=0, pix_r=x[3:0] -> VGA_R equals the previous pixel's x[3:0] during de. All channels are 0 while x>=640 or y>=480.
- mode=1, FRAME_HOLD=2 -> colour index steps 0,1,2..7,0 every 2 frames. Index 5 gives R=F, G=0, B=F.
- mode toggled mid-frame -> output source unchanged until the next frame_start.
- RESET_N pulsed low mid-line at x=300 -> all outputs return to reset values immediately. After release, first pix_ce occurs at x=0, y=0 with frame_start=1.
